// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared types for the adder arbiter slice.
// Holds the FSM state enum and the ID width helper.
package adder_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   // $clog2 clamped to at least 1 so a vector is never zero-wide
   function automatic int ID_W(input int n);
      if (n <= 2) return 1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/adder_rr_picker.sv
// adder_rr_picker: rotate-priority picker starting at rr_ptr.
// Ports: req_valid, rr_ptr in; one-hot grant, grant_idx out.
module adder_rr_picker
   import adder_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IW    = ID_W(N_REQ)
) (
   input  logic [N_REQ-1:0] req_valid,
   input  logic [IW-1:0]    rr_ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IW-1:0]    grant_idx
);

   int          j;
   logic        found;
   logic [IW-1:0] idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      j         = 0;
      idx       = '0;
      for (int k = 0; k < N_REQ; k++) begin
         // walk N_REQ slots from rr_ptr, wrapping once
         j = int'(rr_ptr) + k;
         if (j >= N_REQ) j = j - N_REQ;
         idx = IW'(j);
         if (!found && req_valid[idx]) begin
            found     = 1'b1;
            grant[idx] = 1'b1;
            grant_idx = idx;
         end
      end
   end

endmodule

// File: rtl/nbits_adder.sv
// nbits_adder: combinational unsigned WIDTH-bit adder.
// Ports: a, b in; sum (low WIDTH bits), cout (bit WIDTH) out.
module nbits_adder #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin front end sharing one nbits_adder.
// Ports: clk, rst (sync, high); req_valid/ready/a/b per requester;
// resp_valid/ready/sum/carry/id response channel; busy.
// Define ADDER_ARB_SAT_EN to saturate the sum on carry-out.
module adder_arbiter
   import adder_arb_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N_REQ = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_valid,
   output logic [N_REQ-1:0]         req_ready,
   input  logic [N_REQ*WIDTH-1:0]   req_a,
   input  logic [N_REQ*WIDTH-1:0]   req_b,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [WIDTH-1:0]         resp_sum,
   output logic                     resp_carry,
   output logic [$clog2(N_REQ)-1:0] resp_id,
   output logic                     busy
);

   localparam int IW = ID_W(N_REQ);
   localparam logic [IW-1:0] LAST = IW'(N_REQ - 1);

   arb_state_t       state_q, state_d;
   logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [IW-1:0]    id_q, id_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic [IW-1:0]    rid_q, rid_d;

   logic [N_REQ-1:0] grant;
   logic [IW-1:0]    grant_idx;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic [WIDTH-1:0] add_sum;
   logic             add_carry;

   adder_rr_picker #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_picker (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   nbits_adder #(
      .WIDTH (WIDTH)
   ) u_adder (
      .a    (a_q),
      .b    (b_q),
      .sum  (add_sum),
      .cout (add_carry)
   );

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_a = req_a[i*WIDTH +: WIDTH];
            sel_b = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      a_d        = a_q;
      b_d        = b_q;
      id_d       = id_q;
      sum_d      = sum_q;
      carry_d    = carry_q;
      rid_d      = rid_q;
      req_ready  = '0;
      resp_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            // ready is held off during the reset cycle
            req_ready = rst ? '0 : grant;
            if (|grant) begin
               a_d     = sel_a;
               b_d     = sel_b;
               id_d    = grant_idx;
               state_d = CALC;
            end
         end
         CALC: begin
`ifdef ADDER_ARB_SAT_EN
            sum_d = add_carry ? '1 : add_sum;
`else
            sum_d = add_sum;
`endif
            carry_d = add_carry;
            rid_d   = id_q;
            state_d = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_d  = IDLE;
               rr_ptr_d = (rid_q == LAST) ? '0
                                          : rid_q + IW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         id_q     <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         rid_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         a_q      <= a_d;
         b_q      <= b_d;
         id_q     <= id_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         rid_q    <= rid_d;
      end
   end

   assign busy       = (state_q != IDLE);
   assign resp_sum   = sum_q;
   assign resp_carry = carry_q;
   assign resp_id    = rid_q;

endmodule
